// File: rtl/cpu_subsys_mem_arbiter_pkg.sv
// ============================================================================
// Module      : cpu_subsys_pkg
// Description : Shared types and bus widths for the CPU subsystem memory
//               arbiter: FSM state encoding and SRAM bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_subsys_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2
    } state_e;

endpackage : cpu_subsys_pkg

`default_nettype wire

// File: rtl/cpu_subsys_mem_arbiter_if.sv
// ============================================================================
// Module      : cpu_subsys_mem_arbiter_if
// Description : Bundle of the requester-side and SRAM-side valid/ready buses
//               around the memory arbiter.
//   m_valid/m_addr/m_wdata/m_wstrb : per-master request (wstrb 0 = read)
//   m_ready/m_err                  : per-master completion pulse / error flag
//   m_rdata                        : shared read data, valid with m_ready
//   s_valid/s_addr/s_wdata/s_wstrb : request towards the single SRAM slave
//   s_ready/s_rdata                : slave completion and read data
//   Modports: arbiter (the arbiter itself), master (requesters), slave (SRAM)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_subsys_mem_arbiter_if #(
    parameter int NUM_MASTERS = 2
) ();
    import cpu_subsys_pkg::*;

    logic [NUM_MASTERS-1:0]             m_valid;
    logic [NUM_MASTERS-1:0]             m_ready;
    logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS-1:0][DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS-1:0][STRB_W-1:0] m_wstrb;
    logic [DATA_W-1:0]                  m_rdata;
    logic [NUM_MASTERS-1:0]             m_err;

    logic                               s_valid;
    logic                               s_ready;
    logic [ADDR_W-1:0]                  s_addr;
    logic [DATA_W-1:0]                  s_wdata;
    logic [STRB_W-1:0]                  s_wstrb;
    logic [DATA_W-1:0]                  s_rdata;

    modport arbiter (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, m_err, s_valid, s_addr, s_wdata, s_wstrb
    );

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rdata, m_err
    );

    modport slave (
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata
    );

endinterface : cpu_subsys_mem_arbiter_if

`default_nettype wire

// File: rtl/cpu_subsys_mem_arbiter_rr_pick.sv
// ============================================================================
// Module      : cpu_subsys_rr_pick
// Description : Combinational round-robin selector. Returns the first
//               requesting index found scanning upward from i_last_grant+1
//               (wrapping modulo NUM_MASTERS).
//   i_req        : request vector
//   i_last_grant : index granted most recently
//   o_grant      : selected index (0 when nothing requests)
//   o_any_req    : at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_subsys_rr_pick #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  wire logic [NUM_MASTERS-1:0] i_req,
    input  wire logic [IDX_W-1:0]       i_last_grant,
    output logic      [IDX_W-1:0]       o_grant,
    output logic                        o_any_req
);

    int w_dist;
    int w_best;

    // Each requester's distance from the slot after last_grant; the
    // requester with the smallest distance wins.
    always_comb begin
        o_grant   = '0;
        o_any_req = 1'b0;
        w_best    = NUM_MASTERS;
        w_dist    = 0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            w_dist = (j + NUM_MASTERS - 1 - int'(i_last_grant)) % NUM_MASTERS;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best    = w_dist;
                o_grant   = IDX_W'(j);
                o_any_req = 1'b1;
            end
        end
    end

endmodule : cpu_subsys_rr_pick

`default_nettype wire

// File: rtl/cpu_subsys_mem_arbiter.sv
// ============================================================================
// Module      : cpu_subsys_mem_arbiter
// Description : Round-robin arbiter sharing one single-port SRAM slave with
//               registered one-cycle ready between NUM_MASTERS requesters.
//               One access in flight at a time; a DRAIN cycle after every
//               access swallows the stale ready the slave leaves behind, and
//               a per-access timeout completes with m_err if the slave never
//               answers.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester and slave buses (arbiter modport)
//   busy     : high whenever the FSM is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_subsys_mem_arbiter
    import cpu_subsys_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    cpu_subsys_mem_arbiter_if.arbiter  bus,
    output logic                       busy
);

    localparam int c_IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_MASTERS - 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [c_IDX_W-1:0]   r_grant;
    logic [c_IDX_W-1:0]   w_grant_nxt;
    logic [c_IDX_W-1:0]   r_last_grant;
    logic [c_IDX_W-1:0]   w_last_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;

    logic [c_IDX_W-1:0]   w_pick;
    logic                 w_any_req;

    logic [NUM_MASTERS-1:0] w_m_ready;
    logic [NUM_MASTERS-1:0] w_m_err;
    logic [DATA_W-1:0]      w_m_rdata;
    logic                   w_s_valid;
    logic [ADDR_W-1:0]      w_s_addr;
    logic [DATA_W-1:0]      w_s_wdata;
    logic [STRB_W-1:0]      w_s_wstrb;

    cpu_subsys_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (c_IDX_W)
    ) u_rr_pick (
        .i_req        (bus.m_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick),
        .o_any_req    (w_any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= c_LAST_RST;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last_grant;
        w_cnt_nxt   = r_cnt;
        w_m_ready   = '0;
        w_m_err     = '0;
        w_m_rdata   = '0;
        w_s_valid   = 1'b0;
        w_s_addr    = '0;
        w_s_wdata   = '0;
        w_s_wstrb   = '0;

        case (r_state)
            // DRAIN never looks at s_ready: that is where the slave's
            // leftover ready from the previous access lands.
            IDLE, DRAIN: begin
                if (w_any_req) begin
                    w_state_nxt = ACCESS;
                    w_grant_nxt = w_pick;
                    w_last_nxt  = w_pick;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end

            ACCESS: begin
                w_s_valid = 1'b1;
                w_s_addr  = bus.m_addr[r_grant];
                w_s_wdata = bus.m_wdata[r_grant];
                w_s_wstrb = bus.m_wstrb[r_grant];
                w_m_rdata = bus.s_rdata;
                // Slave completion beats timeout, timeout beats abort.
                if (bus.s_ready) begin
                    w_m_ready[r_grant] = 1'b1;
                    w_state_nxt        = DRAIN;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_m_ready[r_grant] = 1'b1;
                    w_m_err[r_grant]   = 1'b1;
                    w_m_rdata          = '0;
                    w_state_nxt        = DRAIN;
                end else if (!bus.m_valid[r_grant]) begin
                    // Master withdrew its request: drop it silently.
                    w_state_nxt = DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.m_ready = w_m_ready;
    assign bus.m_err   = w_m_err;
    assign bus.m_rdata = w_m_rdata;
    assign bus.s_valid = w_s_valid;
    assign bus.s_addr  = w_s_addr;
    assign bus.s_wdata = w_s_wdata;
    assign bus.s_wstrb = w_s_wstrb;
    assign busy        = (r_state != IDLE);

endmodule : cpu_subsys_mem_arbiter

`default_nettype wire

// File: tb/tb_cpu_subsys_mem_arbiter.sv
// ============================================================================
// Module      : tb_cpu_subsys_mem_arbiter
// Description : Directed self-checking bench for cpu_subsys_mem_arbiter with
//               two masters, TIMEOUT=8 and a registered-ready SRAM model that
//               can be disabled or told to leave a stale ready behind.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_subsys_mem_arbiter;

    localparam int N   = 2;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    cpu_subsys_mem_arbiter_if #(.NUM_MASTERS(N)) bus ();

    cpu_subsys_mem_arbiter #(
        .NUM_MASTERS (N),
        .TIMEOUT     (TMO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM model ----------------
    logic [31:0] mem [0:31];
    logic        bd_we = 1'b0;
    logic [4:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;
    logic        sram_en = 1'b1;
    logic        stale_mode = 1'b0;
    logic        stale_pend;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (sram_en && bus.s_valid) begin
            for (int b = 0; b < 4; b++)
                if (bus.s_wstrb[b])
                    mem[bus.s_addr[6:2]][8*b +: 8] <= bus.s_wdata[8*b +: 8];
        end
        if (rst || !sram_en) begin
            bus.s_ready <= 1'b0;
            stale_pend  <= 1'b0;
        end else if (bus.s_valid && !bus.s_ready) begin
            bus.s_ready <= 1'b1;
            bus.s_rdata <= mem[bus.s_addr[6:2]];
            stale_pend  <= stale_mode;
        end else if (bus.s_ready && stale_pend) begin
            stale_pend  <= 1'b0;
        end else begin
            bus.s_ready <= 1'b0;
        end
    end

    // ---------------- completion monitor ----------------
    int comp_idx[$];
    int comp_cyc[$];
    int comp_data[$];
    int comp_err[$];
    int nspur = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.m_ready != '0) begin
                comp_idx.push_back(bus.m_ready[1] ? 1 : 0);
                comp_cyc.push_back(cyc);
                comp_data.push_back(int'(bus.m_rdata));
                comp_err.push_back(int'(bus.m_err));
                if ($countones(bus.m_ready) != 1) nspur++;
            end else if (bus.m_err != '0) begin
                nspur++;
            end
        end
    end

    // ---------------- helpers ----------------
    logic auto_drop = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [4:0] idx, input logic [31:0] data);
        bd_idx  = idx;
        bd_data = data;
        bd_we   = 1'b1;
        at_edge();
        bd_we   = 1'b0;
    endtask

    task automatic wait_comp(input int target, input int budget, input string tag);
        int n = 0;
        while (comp_idx.size() < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            if (auto_drop) bus.m_valid = bus.m_valid & ~bus.m_ready;
        end
        chk(tag, comp_idx.size(), target);
    endtask

    task automatic do_reset();
        at_edge();
        rst = 1'b1;
        at_edge();
        at_edge();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int b;
        rst         = 1'b1;
        bus.m_valid = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_s_valid", 32'(bus.s_valid), 0);
        chk("rst_m_ready", 32'(bus.m_ready), 0);
        chk("rst_m_err",   32'(bus.m_err), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_s_addr",  bus.s_addr, 0);
        chk("rst_s_wstrb", 32'(bus.s_wstrb), 0);
        chk("rst_m_rdata", bus.m_rdata, 0);

        bd_write(5'h10, 32'hDEADBEEF);
        bd_write(5'h00, 32'h0);
        bd_write(5'h01, 32'h0);
        bd_write(5'h02, 32'hFFFFFFFF);
        rst = 1'b0;

        // Single read by master 0
        at_edge();
        k = cyc;
        b = comp_idx.size();
        bus.m_addr[0]  = 32'h40;
        bus.m_wstrb[0] = 4'h0;
        bus.m_valid    = 2'b01;
        auto_drop      = 1'b1;
        wait_comp(b + 1, 20, "rd_done");
        chk("rd_idx",  q_at(comp_idx, b), 0);
        chk("rd_lat",  q_at(comp_cyc, b) - k, 2);
        chk("rd_data", q_at(comp_data, b), 32'hDEADBEEF);
        chk("rd_err",  q_at(comp_err, b), 0);
        repeat (5) at_edge();
        chk("rd_once", comp_idx.size(), b + 1);

        // Contention: both masters write continuously
        do_reset();
        bus.m_addr[0]  = 32'h0;
        bus.m_wdata[0] = 32'h11111111;
        bus.m_wstrb[0] = 4'hF;
        bus.m_addr[1]  = 32'h4;
        bus.m_wdata[1] = 32'h22222222;
        bus.m_wstrb[1] = 4'hF;
        at_edge();
        k = cyc;
        b = comp_idx.size();
        auto_drop   = 1'b0;
        bus.m_valid = 2'b11;
        wait_comp(b + 4, 40, "cont_done");
        bus.m_valid = 2'b00;
        chk("cont_g0",  q_at(comp_idx, b),     0);
        chk("cont_g1",  q_at(comp_idx, b + 1), 1);
        chk("cont_g2",  q_at(comp_idx, b + 2), 0);
        chk("cont_g3",  q_at(comp_idx, b + 3), 1);
        chk("cont_lat", q_at(comp_cyc, b) - k, 2);
        for (int i = 0; i < 3; i++)
            chk("cont_gap", q_at(comp_cyc, b + i + 1) - q_at(comp_cyc, b + i), 3);
        repeat (4) at_edge();
        chk("cont_cnt",  comp_idx.size(), b + 4);
        chk("cont_mem0", mem[0], 32'h11111111);
        chk("cont_mem1", mem[1], 32'h22222222);

        // Byte strobe passthrough from master 1
        at_edge();
        b = comp_idx.size();
        auto_drop      = 1'b1;
        bus.m_addr[1]  = 32'h8;
        bus.m_wdata[1] = 32'h00AB0000;
        bus.m_wstrb[1] = 4'b0100;
        bus.m_valid    = 2'b10;
        wait_comp(b + 1, 20, "strb_done");
        chk("strb_idx", q_at(comp_idx, b), 1);
        chk("strb_err", q_at(comp_err, b), 0);
        repeat (2) at_edge();
        chk("strb_mem", mem[2], 32'hFFABFFFF);
        bus.m_wstrb[1] = 4'h0;
        bus.m_valid    = 2'b10;
        wait_comp(b + 2, 20, "strb_rd_done");
        chk("strb_rd", q_at(comp_data, b + 1), 32'hFFABFFFF);
        repeat (3) at_edge();

        // Stale ready: slave keeps ready up through the DRAIN cycle
        stale_mode     = 1'b1;
        bus.m_addr[0]  = 32'h40;
        bus.m_wstrb[0] = 4'h0;
        bus.m_addr[1]  = 32'h0;
        bus.m_wstrb[1] = 4'h0;
        at_edge();
        k = cyc;
        b = comp_idx.size();
        bus.m_valid = 2'b11;
        wait_comp(b + 2, 30, "stale_done");
        chk("stale_g0",  q_at(comp_idx, b), 0);
        chk("stale_d0",  q_at(comp_data, b), 32'hDEADBEEF);
        chk("stale_lat", q_at(comp_cyc, b) - k, 2);
        chk("stale_g1",  q_at(comp_idx, b + 1), 1);
        chk("stale_d1",  q_at(comp_data, b + 1), 32'h11111111);
        chk("stale_gap", q_at(comp_cyc, b + 1) - q_at(comp_cyc, b), 3);
        repeat (4) at_edge();
        chk("stale_cnt", comp_idx.size(), b + 2);
        stale_mode = 1'b0;

        // Timeout: slave never answers
        sram_en = 1'b0;
        at_edge();
        k = cyc;
        b = comp_idx.size();
        bus.m_valid = 2'b01;
        wait_comp(b + 1, 30, "tmo_done");
        chk("tmo_idx",  q_at(comp_idx, b), 0);
        chk("tmo_lat",  q_at(comp_cyc, b) - k, TMO);
        chk("tmo_err",  q_at(comp_err, b), 1);
        chk("tmo_data", q_at(comp_data, b), 0);
        @(negedge clk);
        chk("tmo_drain_sv",   32'(bus.s_valid), 0);
        chk("tmo_drain_busy", 32'(busy), 1);
        @(negedge clk);
        chk("tmo_idle_busy",  32'(busy), 0);

        // Abort: master 1 withdraws mid-access; also checks the mux on grant 1
        bus.m_addr[1]  = 32'h14;
        bus.m_wdata[1] = 32'hCAFEF00D;
        bus.m_wstrb[1] = 4'h3;
        at_edge();
        b = comp_idx.size();
        bus.m_valid = 2'b10;
        @(negedge clk);
        @(negedge clk);
        chk("mux_addr",  bus.s_addr, 32'h14);
        chk("mux_wdata", bus.s_wdata, 32'hCAFEF00D);
        chk("mux_wstrb", 32'(bus.s_wstrb), 3);
        at_edge();
        bus.m_valid = 2'b00;
        repeat (5) at_edge();
        chk("abort_cnt",  comp_idx.size(), b);
        chk("abort_busy", 32'(busy), 0);
        sram_en = 1'b1;

        // Reset in the middle of an access
        bus.m_addr[1]  = 32'h4;
        bus.m_wstrb[1] = 4'h0;
        at_edge();
        bus.m_valid = 2'b10;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy_pre", 32'(busy), 1);
        chk("mid_sv_pre",   32'(bus.s_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_sv",   32'(bus.s_valid), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_rdy",  32'(bus.m_ready), 0);
        bus.m_addr[0]  = 32'h40;
        bus.m_wstrb[0] = 4'h0;
        bus.m_valid    = 2'b11;
        at_edge();
        at_edge();
        rst = 1'b0;
        k = cyc;
        b = comp_idx.size();
        wait_comp(b + 1, 20, "post_rst_done");
        chk("post_rst_g0",  q_at(comp_idx, b), 0);
        chk("post_rst_d0",  q_at(comp_data, b), 32'hDEADBEEF);
        chk("post_rst_lat", q_at(comp_cyc, b) - k, 2);
        wait_comp(b + 2, 20, "post_rst_done1");
        chk("post_rst_g1",  q_at(comp_idx, b + 1), 1);
        chk("post_rst_d1",  q_at(comp_data, b + 1), 32'h22222222);
        bus.m_valid = 2'b00;
        repeat (4) at_edge();

        chk("spurious", nspur, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cpu_subsys_mem_arbiter

`default_nettype wire
